uart_tx_sched: RTL and testbench

- Transmit-side controller for the core's 9-bit UART port: bit 8 is a write strobe, bits 7:0 are the byte.
- Queues strobed bytes in a small FIFO and serialises them onto a single 8N1 line using a programmable bit period.
- Emits a one-cycle completion strobe per byte for the simulation console model.
- Sits between the RV32IM core's UART output and the board TX pin / testbench console.

---
 rtl/uart_tx_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Transmit-side controller for the core's 9-bit UART port. Bytes strobed on
// uart_in are queued in a small FIFO and serialised onto an 8N1 line (idle
// high, LSB first) using a programmable bit period. A one-cycle completion
// strobe carrying the byte is raised when each frame's stop bit ends.
//
// Ports:
//   clock       system clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   uart_in     [8] write strobe (one byte per cycle while high), [7:0] byte
//   tx          serial line, registered
//   busy        high whenever the frame FSM is not idle
//   fifo_count  queued bytes (0..FIFO_DEPTH), the byte in flight excluded
//   overflow    sticky flag, set when a strobed byte had to be dropped
//   sent        [8] one-cycle pulse at end of stop bit, [7:0] that byte
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8:0]        uart_in,
  output logic              tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic [8:0]        sent
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  // FSM and datapath state
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [8:0]        sent_q, sent_d;

  // FIFO state
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              last_cycle_s;
  logic              pop_s;
  logic              push_s;
  logic              push_ok_s;
  logic [7:0]        head_s;

  // Pop / push qualification shared by the FIFO and the FSM
  always_comb begin
    last_cycle_s = (cnt_q == CNT_LAST);
    // A pop is only taken when the line is free: idle, or the very last
    // stop-bit cycle so consecutive frames run back to back.
    pop_s = (count_q != COUNT_ZERO) &&
            ((state_q == S_IDLE) || ((state_q == S_STOP) && last_cycle_s));
    push_s = uart_in[8];
    // A full queue still accepts a byte if the head leaves on the same edge.
    push_ok_s = push_s && ((count_q != COUNT_FULL) || pop_s);
    head_s = mem_q[rd_q];
  end

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok_s) begin
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
    if (push_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Frame FSM: next state, bit timing and completion strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sent_d  = 9'h000;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        bit_d = 3'd0;
        if (pop_s) begin
          state_d = S_START;
          shift_d = head_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (last_cycle_s) begin
          state_d = S_DATA;
          cnt_d   = CNT_ZERO;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (last_cycle_s) begin
          cnt_d = CNT_ZERO;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (last_cycle_s) begin
          cnt_d  = CNT_ZERO;
          sent_d = {1'b1, shift_q};
          if (pop_s) begin
            state_d = S_START;
            shift_d = head_s;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Line level and busy follow the state being entered so both are registered
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 9'h000;
      wr_q    <= PTR_ZERO;
      rd_q    <= PTR_ZERO;
      count_q <= COUNT_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Queue storage; stale entries are unreachable once the pointers reset
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_q[wr_q] <= uart_in[7:0];
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign sent       = sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_uart_tx_sched;

  logic       clock;
  logic       reset;
  logic [8:0] uart_in;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [8:0] sent;

  int n_checks = 0;
  int n_pass   = 0;
  int ncyc     = 0;

  logic [8:0] sent_data_q [$];
  int         sent_cyc_q  [$];

  uart_tx_sched #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(8),
    .ADDR_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .uart_in(uart_in),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .sent(sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every completion pulse with the cycle it was seen in
  always @(negedge clock) begin
    ncyc = ncyc + 1;
    if (sent[8] === 1'b1) begin
      sent_data_q.push_back(sent);
      sent_cyc_q.push_back(ncyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Checks 40 cycles of one frame, starting at the first start-bit cycle
  task automatic check_frame(input logic [7:0] b);
    logic e;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) e = 1'b0;
      else if (i == 9) e = 1'b1;
      else e = b[i-1];
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("tx_%02h_bit%0d", b, i), 32'(tx), 32'(e));
        @(negedge clock);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || fifo_count !== 4'd0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(n < 2000), 32'd1);
    @(negedge clock);
  endtask

  task automatic clear_log();
    sent_data_q.delete();
    sent_cyc_q.delete();
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < sent_cyc_q.size(); i++) begin
      chk($sformatf("%s_gap%0d", tag, i), 32'(sent_cyc_q[i] - sent_cyc_q[i-1]), 32'd40);
    end
  endtask

  initial begin
    reset   = 1'b1;
    uart_in = 9'h000;
    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single byte 0x41
    uart_in = 9'h141;
    @(negedge clock);
    uart_in = 9'h000;
    chk("single_count1", 32'(fifo_count), 32'd1);
    chk("single_tx_hi", 32'(tx), 32'd1);
    chk("single_busy0", 32'(busy), 32'd0);
    @(negedge clock);
    chk("single_busy1", 32'(busy), 32'd1);
    chk("single_count0", 32'(fifo_count), 32'd0);
    check_frame(8'h41);
    chk("single_sent", 32'(sent), 32'h141);
    chk("single_busy_drop", 32'(busy), 32'd0);
    chk("single_tx_idle", 32'(tx), 32'd1);
    @(negedge clock);
    chk("single_sent_1cyc", 32'(sent), 32'h000);

    // Back-to-back 0x48, 0x69
    clear_log();
    uart_in = 9'h148;
    @(negedge clock);
    uart_in = 9'h169;
    @(negedge clock);
    uart_in = 9'h000;
    chk("b2b_count", 32'(fifo_count), 32'd1);
    check_frame(8'h48);
    chk("b2b_sent0", 32'(sent), 32'h148);
    chk("b2b_busy_mid", 32'(busy), 32'd1);
    check_frame(8'h69);
    chk("b2b_sent1", 32'(sent), 32'h169);
    chk("b2b_busy_end", 32'(busy), 32'd0);
    @(negedge clock);
    chk("b2b_npulse", 32'(sent_data_q.size()), 32'd2);
    check_spacing("b2b");

    // Held strobe 0x155 for three cycles
    clear_log();
    uart_in = 9'h155;
    repeat (3) @(negedge clock);
    uart_in = 9'h000;
    chk("held_count", 32'(fifo_count), 32'd2);
    wait_idle("held_timeout");
    chk("held_npulse", 32'(sent_data_q.size()), 32'd3);
    for (int i = 0; i < sent_data_q.size(); i++) begin
      chk($sformatf("held_data%0d", i), 32'(sent_data_q[i]), 32'h155);
    end
    check_spacing("held");

    // Overflow: 0x30..0x39 on consecutive cycles
    clear_log();
    for (int i = 0; i < 10; i++) begin
      uart_in = {1'b1, 8'h30 + 8'(i)};
      @(negedge clock);
      if (i == 8) begin
        chk("ovf_count8", 32'(fifo_count), 32'd8);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    uart_in = 9'h000;
    chk("ovf_count_full", 32'(fifo_count), 32'd8);
    chk("ovf_set", 32'(overflow), 32'd1);
    wait_idle("ovf_timeout");
    chk("ovf_npulse", 32'(sent_data_q.size()), 32'd9);
    for (int i = 0; i < sent_data_q.size(); i++) begin
      chk($sformatf("ovf_data%0d", i), 32'(sent_data_q[i]), 32'h130 + 32'(i));
    end
    check_spacing("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset during DATA bit 3 of 0x01 with three bytes queued
    clear_log();
    for (int i = 0; i < 4; i++) begin
      uart_in = {1'b1, 8'h01 + 8'(i)};
      @(negedge clock);
    end
    uart_in = 9'h000;
    chk("rmid_count3", 32'(fifo_count), 32'd3);
    repeat (14) @(negedge clock);
    chk("rmid_bit3", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rmid_tx", 32'(tx), 32'd1);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_count", 32'(fifo_count), 32'd0);
    chk("rmid_ovf", 32'(overflow), 32'd0);
    repeat (100) @(negedge clock);
    chk("rmid_no_sent", 32'(sent_data_q.size()), 32'd0);
    chk("rmid_tx_idle", 32'(tx), 32'd1);
    chk("rmid_busy_idle", 32'(busy), 32'd0);

    // Full queue plus push on the last STOP cycle
    clear_log();
    for (int i = 0; i < 9; i++) begin
      uart_in = {1'b1, 8'h10 + 8'(i)};
      @(negedge clock);
    end
    uart_in = 9'h000;
    chk("full_count8", 32'(fifo_count), 32'd8);
    repeat (32) @(negedge clock);
    chk("full_pre_sent", 32'(sent), 32'h000);
    uart_in = 9'h1AA;
    @(negedge clock);
    uart_in = 9'h000;
    chk("full_sent", 32'(sent), 32'h110);
    chk("full_count_kept", 32'(fifo_count), 32'd8);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    wait_idle("full_timeout");
    chk("full_npulse", 32'(sent_data_q.size()), 32'd10);
    for (int i = 0; i < sent_data_q.size(); i++) begin
      chk($sformatf("full_data%0d", i), 32'(sent_data_q[i]),
          (i < 9) ? (32'h110 + 32'(i)) : 32'h1AA);
    end
    check_spacing("full");
    chk("full_ovf_end", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
